// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle arithmetic/logic ops plus an iterative shift-add
// multiplier and restoring divider that share one 2*WIDTH accumulator.
//
// state | meaning
// IDLE  | waiting for Start_i; operands and opcode latched on accept
// MUL   | shift-add multiply, one multiplier bit per cycle for WIDTH cycles
// DIV   | restoring divide, one quotient bit per cycle for WIDTH cycles
// DONE  | register result and zero flag, pulse Done_o, return to IDLE

module multicycle_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start_i,
  input  logic [3:0]       ALU_Operation_i,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  output logic             Busy_o,
  output logic             Done_o,
  output logic [WIDTH-1:0] ALU_Result_o,
  output logic             Zero_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] ITERS = CW'(WIDTH);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_OR    = 4'b0010;
  localparam logic [3:0] OP_SLL   = 4'b0011;
  localparam logic [3:0] OP_SRL   = 4'b0100;
  localparam logic [3:0] OP_SRA   = 4'b0101;
  localparam logic [3:0] OP_AND   = 4'b0110;
  localparam logic [3:0] OP_XOR   = 4'b0111;
  localparam logic [3:0] OP_SLT   = 4'b1000;
  localparam logic [3:0] OP_SLTU  = 4'b1001;
  localparam logic [3:0] OP_MUL   = 4'b1010;
  localparam logic [3:0] OP_MULHU = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b1100;
  localparam logic [3:0] OP_REMU  = 4'b1101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   alu_res;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    mul_next = {mul_sum, acc[WIDTH-1:1]};
  end

  // Divide: acc = {remainder, dividend/quotient}; a zero divisor naturally yields
  // an all-ones quotient and a remainder equal to the dividend.
  always_comb begin
    rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    div_ge   = (rem_sh >= {1'b0, b_q});
    div_diff = rem_sh[WIDTH-1:0] - b_q;
    if (div_ge) begin
      div_next = {div_diff, acc[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    alu_res = '0;
    case (op_q)
      OP_ADD:   alu_res = a_q + b_q;
      OP_SUB:   alu_res = a_q - b_q;
      OP_OR:    alu_res = a_q | b_q;
      OP_SLL:   alu_res = a_q << b_q[SHW-1:0];
      OP_SRL:   alu_res = a_q >> b_q[SHW-1:0];
      OP_SRA:   alu_res = $signed(a_q) >>> b_q[SHW-1:0];
      OP_AND:   alu_res = a_q & b_q;
      OP_XOR:   alu_res = a_q ^ b_q;
      OP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
      OP_MUL:   alu_res = acc[WIDTH-1:0];
      OP_MULHU: alu_res = acc[2*WIDTH-1:WIDTH];
      OP_DIVU:  alu_res = acc[WIDTH-1:0];
      OP_REMU:  alu_res = acc[2*WIDTH-1:WIDTH];
      default:  alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      acc          <= '0;
      cnt          <= '0;
      Busy_o       <= 1'b0;
      Done_o       <= 1'b0;
      ALU_Result_o <= '0;
      Zero_o       <= 1'b1;
    end else begin
      Done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (Start_i) begin
            op_q   <= ALU_Operation_i;
            a_q    <= A_i;
            b_q    <= B_i;
            cnt    <= ITERS;
            Busy_o <= 1'b1;
            case (ALU_Operation_i)
              OP_MUL, OP_MULHU: begin
                acc   <= {{WIDTH{1'b0}}, B_i};
                state <= MUL;
              end
              OP_DIVU, OP_REMU: begin
                acc   <= {{WIDTH{1'b0}}, A_i};
                state <= DIV;
              end
              default: state <= DONE;
            endcase
          end
        end
        MUL: begin
          acc <= mul_next;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= DONE;
        end
        DIV: begin
          acc <= div_next;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= DONE;
        end
        DONE: begin
          ALU_Result_o <= alu_res;
          Zero_o       <= (alu_res == '0);
          Done_o       <= 1'b1;
          Busy_o       <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          state  <= IDLE;
          Busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu (WIDTH=32): expected results are queued
// when an operation is started and compared when Done_o is observed.

module tb_multicycle_alu;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_OR    = 4'b0010;
  localparam logic [3:0] OP_SLL   = 4'b0011;
  localparam logic [3:0] OP_SRL   = 4'b0100;
  localparam logic [3:0] OP_SRA   = 4'b0101;
  localparam logic [3:0] OP_AND   = 4'b0110;
  localparam logic [3:0] OP_XOR   = 4'b0111;
  localparam logic [3:0] OP_SLT   = 4'b1000;
  localparam logic [3:0] OP_SLTU  = 4'b1001;
  localparam logic [3:0] OP_MUL   = 4'b1010;
  localparam logic [3:0] OP_MULHU = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b1100;
  localparam logic [3:0] OP_REMU  = 4'b1101;

  logic        clk;
  logic        reset;
  logic        Start_i;
  logic [3:0]  ALU_Operation_i;
  logic [31:0] A_i;
  logic [31:0] B_i;
  logic        Busy_o;
  logic        Done_o;
  logic [31:0] ALU_Result_o;
  logic        Zero_o;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } vec_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  multicycle_alu #(.WIDTH(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .Start_i         (Start_i),
    .ALU_Operation_i (ALU_Operation_i),
    .A_i             (A_i),
    .B_i             (B_i),
    .Busy_o          (Busy_o),
    .Done_o          (Done_o),
    .ALU_Result_o    (ALU_Result_o),
    .Zero_o          (Zero_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] r;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      OP_ADD:   r = a + b;
      OP_SUB:   r = a - b;
      OP_OR:    r = a | b;
      OP_SLL:   r = a << b[4:0];
      OP_SRL:   r = a >> b[4:0];
      OP_SRA:   r = $signed(a) >>> b[4:0];
      OP_AND:   r = a & b;
      OP_XOR:   r = a ^ b;
      OP_SLT:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU:  r = (a < b) ? 32'd1 : 32'd0;
      OP_MUL:   r = p[31:0];
      OP_MULHU: r = p[63:32];
      OP_DIVU:  r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      OP_REMU:  r = (b == 32'd0) ? a : a % b;
      default:  r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic int model_lat(input logic [3:0] op);
    return (op >= OP_MUL && op <= OP_REMU) ? 33 : 1;
  endfunction

  // Called at a negedge; returns at the following negedge with Start_i low and
  // the operand inputs scrambled so a design that fails to latch them is exposed.
  task automatic drive_start(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] res, input int lat);
    exp_t e;
    Start_i         = 1'b1;
    ALU_Operation_i = op;
    A_i             = a;
    B_i             = b;
    e.res = res;
    e.lat = lat;
    sb_q.push_back(e);
    @(negedge clk);
    Start_i         = 1'b0;
    ALU_Operation_i = 4'($urandom);
    A_i             = ~a;
    B_i             = $urandom;
  endtask

  task automatic wait_done(input int start, output int cycles);
    cycles = start;
    while (Done_o !== 1'b1 && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    Start_i = 1'b0;
    ALU_Operation_i = 4'd0;
    A_i = 32'd0;
    B_i = 32'd0;
    repeat (3) @(negedge clk);
    total++; if (Busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", Busy_o); end
    total++; if (Done_o !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", Done_o); end
    total++; if (ALU_Result_o !== 32'd0) begin bad++; $display("FAIL reset_result got=%h want=0", ALU_Result_o); end
    total++; if (Zero_o !== 1'b1) begin bad++; $display("FAIL reset_zero got=%b want=1", Zero_o); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_add_sub_back_to_back();
    int   cyc;
    exp_t e;
    drive_start(OP_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1);
    for (int i = 0; i < 2; i++) begin
      wait_done(0, cyc);
      e = sb_q.pop_front();
      total++; if (cyc !== e.lat) begin bad++; $display("FAIL b2b_latency[%0d] got=%0d want=%0d", i, cyc, e.lat); end
      total++; if (Done_o !== 1'b1 || ALU_Result_o !== e.res) begin bad++; $display("FAIL b2b_result[%0d] got=%h want=%h", i, ALU_Result_o, e.res); end
      total++; if (Zero_o !== (e.res == 32'd0)) begin bad++; $display("FAIL b2b_zero[%0d] got=%b want=%b", i, Zero_o, (e.res == 32'd0)); end
      if (i == 0) begin
        drive_start(OP_SUB, 32'd5, 32'd5, 32'd0, 1);
        total++; if (Done_o !== 1'b0 || Busy_o !== 1'b1) begin bad++; $display("FAIL b2b_pulse done=%b busy=%b want done=0 busy=1", Done_o, Busy_o); end
      end
    end
  endtask

  task automatic test_single_cycle_ops();
    vec_t tbl[11];
    int   cyc;
    exp_t e;
    tbl[0]  = '{OP_SRA,  32'h8000_0000, 32'h0000_0021, 32'hC000_0000};
    tbl[1]  = '{OP_SLT,  32'hFFFF_FFFF, 32'd1,         32'd1};
    tbl[2]  = '{OP_SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0};
    tbl[3]  = '{OP_SLL,  32'h0000_0001, 32'h0000_0024, 32'h0000_0010};
    tbl[4]  = '{OP_SRL,  32'h8000_0000, 32'h0000_001F, 32'h0000_0001};
    tbl[5]  = '{OP_OR,   32'hF0F0_0000, 32'h0000_F0F0, 32'hF0F0_F0F0};
    tbl[6]  = '{OP_AND,  32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00};
    tbl[7]  = '{OP_XOR,  32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00};
    tbl[8]  = '{4'b1110, 32'h1234_5678, 32'd1,         32'd0};
    tbl[9]  = '{4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
    tbl[10] = '{OP_SUB,  32'd0,         32'd1,         32'hFFFF_FFFF};
    for (int i = 0; i < 11; i++) begin
      drive_start(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, 1);
      wait_done(0, cyc);
      e = sb_q.pop_front();
      total++; if (cyc !== e.lat) begin bad++; $display("FAIL single_latency[%0d] got=%0d want=%0d", i, cyc, e.lat); end
      total++; if (Done_o !== 1'b1 || ALU_Result_o !== e.res) begin bad++; $display("FAIL single_result[%0d] got=%h want=%h", i, ALU_Result_o, e.res); end
      total++; if (Zero_o !== (e.res == 32'd0)) begin bad++; $display("FAIL single_zero[%0d] got=%b want=%b", i, Zero_o, (e.res == 32'd0)); end
    end
  endtask

  task automatic test_mul_div();
    vec_t tbl[10];
    int   cyc;
    exp_t e;
    tbl[0] = '{OP_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    tbl[1] = '{OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    tbl[2] = '{OP_DIVU,  32'd100,       32'd7,         32'd14};
    tbl[3] = '{OP_REMU,  32'd100,       32'd7,         32'd2};
    tbl[4] = '{OP_DIVU,  32'd9,         32'd0,         32'hFFFF_FFFF};
    tbl[5] = '{OP_REMU,  32'd9,         32'd0,         32'd9};
    tbl[6] = '{OP_MUL,   32'd12345,     32'd6789,      32'd83810205};
    tbl[7] = '{OP_MULHU, 32'h8000_0000, 32'd4,         32'd2};
    tbl[8] = '{OP_DIVU,  32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF};
    tbl[9] = '{OP_REMU,  32'd0,         32'd5,         32'd0};
    for (int i = 0; i < 10; i++) begin
      drive_start(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, 33);
      wait_done(0, cyc);
      e = sb_q.pop_front();
      total++; if (cyc !== e.lat) begin bad++; $display("FAIL muldiv_latency[%0d] got=%0d want=%0d", i, cyc, e.lat); end
      total++; if (Done_o !== 1'b1 || ALU_Result_o !== e.res) begin bad++; $display("FAIL muldiv_result[%0d] got=%h want=%h", i, ALU_Result_o, e.res); end
      total++; if (Zero_o !== (e.res == 32'd0)) begin bad++; $display("FAIL muldiv_zero[%0d] got=%b want=%b", i, Zero_o, (e.res == 32'd0)); end
    end
  endtask

  task automatic test_busy_drop();
    int   cyc;
    int   extra;
    exp_t e;
    drive_start(OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
    repeat (3) @(negedge clk);
    Start_i = 1'b1;
    ALU_Operation_i = OP_ADD;
    A_i = 32'd1;
    B_i = 32'd2;
    total++; if (Busy_o !== 1'b1) begin bad++; $display("FAIL drop_busy got=%b want=1", Busy_o); end
    @(negedge clk);
    Start_i = 1'b0;
    wait_done(4, cyc);
    e = sb_q.pop_front();
    total++; if (cyc !== e.lat) begin bad++; $display("FAIL drop_latency got=%0d want=%0d", cyc, e.lat); end
    total++; if (Done_o !== 1'b1 || ALU_Result_o !== e.res) begin bad++; $display("FAIL drop_result got=%h want=%h", ALU_Result_o, e.res); end
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (Done_o === 1'b1 || Busy_o === 1'b1) extra++;
    end
    total++; if (extra !== 0) begin bad++; $display("FAIL drop_no_extra got=%0d active cycles want=0", extra); end
  endtask

  task automatic test_reset_abort();
    int   cyc;
    int   extra;
    exp_t e;
    Start_i = 1'b1;
    ALU_Operation_i = OP_DIVU;
    A_i = 32'd1000;
    B_i = 32'd3;
    @(negedge clk);
    Start_i = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (Busy_o !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", Busy_o); end
    total++; if (Done_o !== 1'b0) begin bad++; $display("FAIL abort_done got=%b want=0", Done_o); end
    total++; if (ALU_Result_o !== 32'd0) begin bad++; $display("FAIL abort_result got=%h want=0", ALU_Result_o); end
    total++; if (Zero_o !== 1'b1) begin bad++; $display("FAIL abort_zero got=%b want=1", Zero_o); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (Done_o === 1'b1) extra++;
    end
    total++; if (extra !== 0) begin bad++; $display("FAIL abort_no_done got=%0d done pulses want=0", extra); end
    drive_start(OP_ADD, 32'd3, 32'd4, 32'd7, 1);
    wait_done(0, cyc);
    e = sb_q.pop_front();
    total++; if (cyc !== e.lat) begin bad++; $display("FAIL abort_add_latency got=%0d want=%0d", cyc, e.lat); end
    total++; if (Done_o !== 1'b1 || ALU_Result_o !== e.res) begin bad++; $display("FAIL abort_add_result got=%h want=%h", ALU_Result_o, e.res); end
    total++; if (Zero_o !== 1'b0) begin bad++; $display("FAIL abort_add_zero got=%b want=0", Zero_o); end
  endtask

  task automatic test_random();
    int          cyc;
    exp_t        e;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 24; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = (i % 3 == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      drive_start(op, a, b, model(op, a, b), model_lat(op));
      wait_done(0, cyc);
      if (sb_q.size() == 0) begin
        total++; bad++;
        $display("FAIL rand_scoreboard[%0d] got=empty queue want=1 entry", i);
      end else begin
        e = sb_q.pop_front();
        total++; if (cyc !== e.lat) begin bad++; $display("FAIL rand_latency[%0d] op=%h got=%0d want=%0d", i, op, cyc, e.lat); end
        total++; if (Done_o !== 1'b1 || ALU_Result_o !== e.res) begin bad++; $display("FAIL rand_result[%0d] op=%h a=%h b=%h got=%h want=%h", i, op, a, b, ALU_Result_o, e.res); end
        total++; if (Zero_o !== (e.res == 32'd0)) begin bad++; $display("FAIL rand_zero[%0d] got=%b want=%b", i, Zero_o, (e.res == 32'd0)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_sub_back_to_back();
    test_single_cycle_ops();
    test_mul_div();
    test_busy_drop();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; SHALL be a power of two, 8..64.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width taken from B_i[SHW-1:0].
REQ-003 clk  input  1  rising-edge clock; single clock domain.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 Start_i  input  1  operation request, sampled on rising clk edge.
REQ-006 ALU_Operation_i  input  4  opcode, sampled with Start_i.
REQ-007 A_i  input  WIDTH  operand A, sampled with Start_i.
REQ-008 B_i  input  WIDTH  operand B, sampled with Start_i.
REQ-009 Busy_o  output  1  high while an operation is in flight; Start_i is ignored.
REQ-010 Done_o  output  1  one-cycle pulse; ALU_Result_o and Zero_o are valid.
REQ-011 ALU_Result_o  output  WIDTH  registered result, held until the next Done_o.
REQ-012 Zero_o  output  1  registered, equals (ALU_Result_o == 0), updated with Done_o.

Function
REQ-013 Opcodes SHALL be: 0000 ADD, 0001 SUB, 0010 OR, 0011 SLL, 0100 SRL (logical), 0101 SRA, 0110 AND, 0111 XOR, 1000 SLT (signed, result 0/1), 1001 SLTU, 1010 MUL (low WIDTH bits), 1011 MULHU (high WIDTH bits, unsigned), 1100 DIVU, 1101 REMU; 1110 and 1111 return 0.
REQ-014 Operands and the opcode SHALL be latched into internal registers on an accepted Start_i; later input changes SHALL NOT affect the operation in flight.
REQ-015 The FSM SHALL have the states IDLE, MUL, DIV and DONE.
REQ-016 IDLE + Start_i with a single-cycle opcode (0000-1001, 1110, 1111) SHALL go to DONE; the result is computed from the latched operands.
REQ-017 IDLE + Start_i with MUL/MULHU SHALL go to MUL; with DIVU/REMU it SHALL go to DIV.
REQ-018 MUL SHALL run a shift-add over exactly WIDTH cycles using a 2*WIDTH-bit accumulator, then go to DONE.
REQ-019 DIV SHALL run a restoring divide over exactly WIDTH cycles, one quotient bit per cycle, then go to DONE.
REQ-020 DONE SHALL assert Done_o for one cycle, update ALU_Result_o/Zero_o, and return to IDLE.
REQ-021 Latency from the Start_i edge to Done_o high SHALL be 1 cycle for single-cycle ops and WIDTH+1 cycles for MUL/MULHU/DIVU/REMU.
REQ-022 Busy_o SHALL be high in MUL, DIV and DONE, and low in IDLE.
REQ-023 Start_i in IDLE during the cycle Done_o is high SHALL be accepted, giving back-to-back throughput.
REQ-024 Start_i while Busy_o is high SHALL be dropped silently, with no queuing.
REQ-025 Divide by zero: DIVU SHALL return all-ones and REMU SHALL return A; the latency SHALL still be WIDTH+1.
REQ-026 Shifts SHALL use B[SHW-1:0] only; SRA SHALL replicate A[WIDTH-1].
REQ-027 ADD, SUB and MUL SHALL wrap modulo 2^WIDTH, with no overflow flag.
REQ-028 A counter of $clog2(WIDTH)+1 bits SHALL count iterations; it reloads on each accepted Start_i.

Reset
REQ-029 reset low SHALL immediately force: state IDLE, Busy_o=0, Done_o=0, ALU_Result_o=0, Zero_o=1, counter and internal registers = 0.
REQ-030 reset asserted mid-operation SHALL abort the operation with no Done_o; the first Start_i after release SHALL start a fresh operation.
REQ-031 Deassertion SHALL be synchronised by the integrating level; the block requires no Start_i in the first cycle after release.

Verification (WIDTH=32)
REQ-032 Start ADD A=0x7FFFFFFF, B=1 -> Done_o one cycle later, result 0x80000000, Zero_o=0; then SUB A=5, B=5 back-to-back -> result 0, Zero_o=1.
REQ-033 MUL A=0xFFFFFFFF, B=0xFFFFFFFF -> Done_o at cycle 33, MUL result 0x00000001; MULHU on the same operands -> 0xFFFFFFFE.
REQ-034 DIVU A=100, B=7 -> result 14 at cycle 33; REMU on the same operands -> 2; DIVU A=9, B=0 -> 0xFFFFFFFF; REMU A=9, B=0 -> 9.
REQ-035 SRA A=0x80000000, B=0x21 -> 0xC0000000; SLT A=-1, B=1 -> 1; SLTU on the same operands -> 0.
REQ-036 Start DIVU, pulse Start_i with ADD at cycle 5 -> ADD ignored and the DIVU result is correct; start DIVU, assert reset at cycle 10 -> outputs at reset values, no Done_o, and the next ADD completes normally.
